// File: rtl/dec_key_encoder_v_if.sv
// dec_key_encoder_v_if: BCD event output bus with valid/ready handshake and overrun flag
interface dec_key_encoder_v_if;
    logic [3:0] o_bcd;
    logic       o_valid;
    logic       o_multi;
    logic       o_overrun;
    logic       i_ready;
    modport master (output o_bcd, o_valid, o_multi, o_overrun, input i_ready);
    modport slave  (input o_bcd, o_valid, o_multi, o_overrun, output i_ready);
endinterface

// File: rtl/dec_key_encoder_v.sv
// dec_key_encoder_v: synchronizes, debounces and priority-encodes ten active-low decimal lines into one BCD event per press
module dec_key_encoder_v #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_n_rst,
    input  logic [9:0]          i_n_key,
    input  logic                i_en,
    dec_key_encoder_v_if.master bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;
    localparam logic [7:0] CNT_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    logic [9:0] r_sync1, r_sync2;
    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_cand;
    logic [3:0] r_bcd;
    logic       r_valid, r_multi, r_overrun;
    logic [9:0] w_k;
    logic [3:0] w_enc;
    logic       w_any, w_multi, w_emit, w_xfer, w_load;
    assign w_k     = ~r_sync2;
    assign w_any   = |w_k;
    // clearing the lowest set bit leaves something only if two or more were set
    assign w_multi = |(w_k & (w_k - 10'd1));
    always_comb begin
        w_enc = 4'd0;
        for (int i = 0; i < 10; i++)
            if (w_k[i]) w_enc = 4'(i);
    end
    assign w_emit = i_en && r_state == ST_DEBOUNCE && w_any && w_enc == r_cand && r_cnt == CNT_LAST;
    assign w_xfer = r_valid & bus.i_ready;
    assign w_load = w_emit & (~r_valid | w_xfer);
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_sync1 <= 10'h3FF;
            r_sync2 <= 10'h3FF;
        end else begin
            r_sync1 <= i_n_key;
            r_sync2 <= r_sync1;
        end
    end
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_cand  <= 4'd0;
        end else if (!i_en) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE:
                    if (w_any) begin
                        r_cand  <= w_enc;
                        r_cnt   <= 8'd0;
                        r_state <= ST_DEBOUNCE;
                    end
                ST_DEBOUNCE:
                    if (!w_any) r_state <= ST_IDLE;
                    else if (w_enc != r_cand) begin
                        r_cand <= w_enc;
                        r_cnt  <= 8'd0;
                    end else if (r_cnt == CNT_LAST) r_state <= ST_PRESSED;
                    else r_cnt <= r_cnt + 8'd1;
                ST_PRESSED:
                    if (!w_any) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_RELEASE;
                    end
                default:
                    if (w_any) r_state <= ST_PRESSED;
                    else if (r_cnt == CNT_LAST) r_state <= ST_IDLE;
                    else r_cnt <= r_cnt + 8'd1;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_bcd     <= 4'd0;
            r_multi   <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_bcd   <= r_cand;
                r_multi <= w_multi;
                r_valid <= 1'b1;
            end else if (w_xfer) r_valid <= 1'b0;
            if (w_emit & r_valid & ~bus.i_ready) r_overrun <= 1'b1;
            else if (w_xfer) r_overrun <= 1'b0;
        end
    end
    assign bus.o_bcd     = r_bcd;
    assign bus.o_multi   = r_multi;
    assign bus.o_valid   = r_valid;
    assign bus.o_overrun = r_overrun;
endmodule
